// File: rtl/mutative_tag_ctrl.sv
// Access controller for the mutative cache tag SRAM: clears every entry after
// reset or on flush, and shares the single RW port between lookups and updates.
module mutative_tag_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req,
  output logic                  busy,
  // Handshakes: a request transfers on a cycle where its valid and ready are
  // both high at the clock edge; ready never depends on the same channel's valid.
  input  logic                  lkp_valid,
  output logic                  lkp_ready,
  input  logic [ADDR_WIDTH-1:0] lkp_idx,
  input  logic [DATA_WIDTH-2:0] lkp_tag,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [DATA_WIDTH-1:0] rsp_entry,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [ADDR_WIDTH-1:0] upd_idx,
  input  logic [DATA_WIDTH-1:0] upd_data,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic [1:0]            dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] din_q;
  logic [DATA_WIDTH-1:0] din_d;
  logic [DATA_WIDTH-2:0] tag_q;
  logic                  rsp_pending_q;
  logic                  csb_d;
  logic                  web_d;
  logic                  clearing;
  logic                  upd_grant;
  logic                  lkp_grant;

  assign clearing  = (state_q != IDLE);
  assign upd_ready = (state_q == IDLE) & ~flush_req;
  assign lkp_ready = (state_q == IDLE) & ~flush_req & ~upd_valid;
  assign upd_grant = upd_valid & upd_ready;
  assign lkp_grant = lkp_valid & lkp_ready;
  assign busy      = clearing;
  assign dbg_state = state_q;

  // Address and data hold their last driven value on cycles with no access.
  always_comb begin
    csb_d  = 1'b1;
    web_d  = 1'b1;
    addr_d = addr_q;
    din_d  = din_q;
    if (clearing) begin
      csb_d  = 1'b0;
      web_d  = 1'b0;
      addr_d = cnt_q;
      din_d  = '0;
    end else if (upd_grant) begin
      csb_d  = 1'b0;
      web_d  = 1'b0;
      addr_d = upd_idx;
      din_d  = upd_data;
    end else if (lkp_grant) begin
      csb_d  = 1'b0;
      addr_d = lkp_idx;
    end
  end

  // The reset state is INIT, so the strobes are forced idle while rst is high.
  assign sram_csb0  = rst | csb_d;
  assign sram_web0  = rst | web_d;
  assign sram_addr0 = addr_d;
  assign sram_din0  = din_d;

  assign rsp_valid = rsp_pending_q;
  assign rsp_entry = rsp_pending_q ? sram_dout0 : '0;
  assign rsp_hit   = rsp_pending_q & sram_dout0[DATA_WIDTH-1] &
                     (sram_dout0[DATA_WIDTH-2:0] == tag_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= INIT;
      cnt_q         <= '0;
      addr_q        <= '0;
      din_q         <= '0;
      tag_q         <= '0;
      rsp_pending_q <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      din_q         <= din_d;
      rsp_pending_q <= lkp_grant;
      if (lkp_grant) tag_q <= lkp_tag;
      case (state_q)
        INIT, FLUSH: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_q <= IDLE;
        end
        IDLE: begin
          if (flush_req) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

endmodule
